// File: rtl/aes256_round_key_store.sv
// AES-256 round-key store: captures 15 round keys from the key expander and serves them
// forward or reverse over a valid/ready handshake. Optional per-byte parity: AES_RKS_PARITY_EN.
module aes256_round_key_store #(
  parameter int KW       = 128,
  parameter int NUM_KEYS = 15,
  parameter int IDX_W    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_start,
  input  logic [KW-1:0]    short_key_hi,
  input  logic [KW-1:0]    skey_in,
  input  logic             skey_valid,
  input  logic [IDX_W-1:0] skey_cnt,
  output logic             keys_ready,
  input  logic             run_start,
  input  logic             run_dir,
  output logic [KW-1:0]    rk_out,
  output logic [IDX_W-1:0] rk_idx,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic             rk_last,
  output logic             run_done,
`ifdef AES_RKS_PARITY_EN
  output logic             parity_err,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READY, S_RUN} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);

  state_t               state, state_nxt;
  logic [KW-1:0]        slot_mem [NUM_KEYS];
  logic [NUM_KEYS-1:0]  slot_valid, slot_valid_nxt;
  logic                 dir_q;

  logic                 skey_wr;
  logic                 xfer;
  logic                 serve_start;
  logic                 load_rk;
  logic                 eff_dir;
  logic [IDX_W-1:0]     next_idx;
  logic [IDX_W-1:0]     load_idx;

  // Expander writes are only honoured while loading, and never in the load_start cycle.
  assign skey_wr     = (state == S_LOAD) && !load_start && skey_valid &&
                       (skey_cnt != '0) && (skey_cnt <= LAST_IDX);
  assign xfer        = rk_valid && rk_ready;
  assign serve_start = (state == S_READY) && run_start && !load_start;
  assign eff_dir     = serve_start ? run_dir : dir_q;
  assign next_idx    = dir_q ? (rk_idx - 1'b1) : (rk_idx + 1'b1);
  assign load_idx    = serve_start ? (run_dir ? LAST_IDX : IDX_W'(0)) : next_idx;
  assign load_rk     = serve_start || ((state == S_RUN) && xfer && !rk_last && !load_start);

  assign keys_ready  = (state == S_READY) || (state == S_RUN);
  assign busy        = (state == S_LOAD) || (state == S_RUN);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    slot_valid_nxt = slot_valid;
    if (skey_wr) slot_valid_nxt = slot_valid | (NUM_KEYS'(1) << skey_cnt);
  end

  always_comb begin
    state_nxt = state;
    if (load_start) begin
      state_nxt = S_LOAD;
    end else begin
      unique case (state)
        S_LOAD:  if (&slot_valid_nxt) state_nxt = S_READY;
        S_READY: if (run_start) state_nxt = S_RUN;
        S_RUN:   if (xfer && rk_last) state_nxt = S_READY;
        default: state_nxt = state;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

`ifdef AES_RKS_PARITY_EN
  logic [KW/8-1:0] slot_par [NUM_KEYS];

  function automatic logic [KW/8-1:0] byte_par(input logic [KW-1:0] d);
    byte_par = '0;
    for (int b = 0; b < KW/8; b++) byte_par[b] = ^d[8*b +: 8];
  endfunction
`endif

  // NOTE: key storage has no reset; slot_valid alone says which contents are meaningful.
  always_ff @(posedge clk) begin
    if (load_start) begin
      slot_mem[0] <= short_key_hi;
`ifdef AES_RKS_PARITY_EN
      slot_par[0] <= byte_par(short_key_hi);
`endif
    end
    if (skey_wr) begin
      slot_mem[skey_cnt] <= skey_in;
`ifdef AES_RKS_PARITY_EN
      slot_par[skey_cnt] <= byte_par(skey_in);
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid <= '0;
      dir_q      <= 1'b0;
      rk_out     <= '0;
      rk_idx     <= '0;
      rk_valid   <= 1'b0;
      rk_last    <= 1'b0;
      run_done   <= 1'b0;
    end else begin
      run_done <= 1'b0;
      if (load_start) begin
        slot_valid <= NUM_KEYS'(1);
        rk_valid   <= 1'b0;
        rk_last    <= 1'b0;
      end else begin
        if (skey_wr)     slot_valid <= slot_valid_nxt;
        if (serve_start) dir_q      <= run_dir;
        if (load_rk) begin
          rk_out   <= slot_mem[load_idx];
          rk_idx   <= load_idx;
          rk_valid <= 1'b1;
          rk_last  <= (load_idx == (eff_dir ? IDX_W'(0) : LAST_IDX));
        end else if ((state == S_RUN) && xfer && rk_last) begin
          rk_valid <= 1'b0;
          rk_last  <= 1'b0;
          run_done <= 1'b1;
        end
      end
    end
  end

`ifdef AES_RKS_PARITY_EN
  // Parity is rechecked whenever a key is moved to rk_out; the flag is sticky until reload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        parity_err <= 1'b0;
    else if (load_start) parity_err <= 1'b0;
    else if (load_rk)    parity_err <= parity_err |
                                       (byte_par(slot_mem[load_idx]) != slot_par[load_idx]);
  end
`endif

endmodule

// File: tb/tb_aes256_round_key_store.sv
// Directed bench for aes256_round_key_store using the FIPS-197 AES-256 example key schedule.
module tb_aes256_round_key_store;

  localparam int KW    = 128;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             load_start;
  logic [KW-1:0]    short_key_hi;
  logic [KW-1:0]    skey_in;
  logic             skey_valid;
  logic [IDX_W-1:0] skey_cnt;
  logic             keys_ready;
  logic             run_start;
  logic             run_dir;
  logic [KW-1:0]    rk_out;
  logic [IDX_W-1:0] rk_idx;
  logic             rk_valid;
  logic             rk_ready;
  logic             rk_last;
  logic             run_done;
  logic             busy;
`ifdef AES_RKS_PARITY_EN
  logic             parity_err;
`endif

  int checks = 0;
  int errors = 0;

  logic [KW-1:0] rk_tab [15] = '{
    128'h603deb1015ca71be2b73aef0857d7781,
    128'h1f352c073b6108d72d9810a30914dff4,
    128'h9ba354118e6925afa51a8b5f2067fcde,
    128'ha8b09c1a93d194cdbe49846eb75d5b9a,
    128'hd59aecb85bf3c917fee94248de8ebe96,
    128'hb5a9328a2678a647983122292f6c79b3,
    128'h812c81addadf48ba24360af2fab8b464,
    128'h98c5bfc9bebd198e268c3ba709e04214,
    128'h68007bacb2df331696e939e46c518d80,
    128'hc814e20476a9fb8a5025c02d59c58239,
    128'hde1369676ccc5a71fa2563959674ee15,
    128'h5886ca5d2e2f31d77e0af1fa27cf73c3,
    128'h749c47ab18501ddae2757e4f7401905a,
    128'hcafaaae3e4d59b349adf6acebd10190d,
    128'hfe4890d1e6188d0b046df344706c631e
  };

  aes256_round_key_store dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .load_start   (load_start),
    .short_key_hi (short_key_hi),
    .skey_in      (skey_in),
    .skey_valid   (skey_valid),
    .skey_cnt     (skey_cnt),
    .keys_ready   (keys_ready),
    .run_start    (run_start),
    .run_dir      (run_dir),
    .rk_out       (rk_out),
    .rk_idx       (rk_idx),
    .rk_valid     (rk_valid),
    .rk_ready     (rk_ready),
    .rk_last      (rk_last),
    .run_done     (run_done),
`ifdef AES_RKS_PARITY_EN
    .parity_err   (parity_err),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [KW-1:0] observed, input logic [KW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_bit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check    ({tag, "_rk_out"},     rk_out, '0);
    check    ({tag, "_rk_idx"},     KW'(rk_idx), '0);
    check_bit({tag, "_rk_valid"},   rk_valid, 1'b0);
    check_bit({tag, "_rk_last"},    rk_last, 1'b0);
    check_bit({tag, "_keys_ready"}, keys_ready, 1'b0);
    check_bit({tag, "_run_done"},   run_done, 1'b0);
    check_bit({tag, "_busy"},       busy, 1'b0);
  endtask

  // Expander model: streams slots 1..14, with ignored counts 0 and 15 just before slot 14.
  task automatic stream_keys();
    for (int i = 1; i <= 14; i++) begin
      if (i == 14) begin
        check_bit("pre14_keys_ready", keys_ready, 1'b0);
        skey_valid = 1'b1; skey_cnt = 4'd0;  skey_in = '1; step();
        skey_valid = 1'b1; skey_cnt = 4'd15; skey_in = '1; step();
      end
      skey_valid = 1'b1;
      skey_cnt   = IDX_W'(i);
      skey_in    = rk_tab[i];
      step();
    end
    skey_valid = 1'b0;
    skey_in    = '0;
    check_bit("post14_keys_ready", keys_ready, 1'b1);
    check_bit("post14_busy", busy, 1'b0);
  endtask

  task automatic do_load();
    load_start   = 1'b1;
    short_key_hi = rk_tab[0];
    skey_valid   = 1'b1;
    skey_cnt     = 4'd0;
    skey_in      = '1;
    step();
    load_start   = 1'b0;
    skey_valid   = 1'b0;
    check_bit("load_busy", busy, 1'b1);
    check_bit("load_keys_ready", keys_ready, 1'b0);
    stream_keys();
  endtask

  // Full run with rk_ready held high: 15 keys on 15 consecutive cycles, then run_done.
  task automatic full_run(input logic dir);
    int k;
    run_dir   = dir;
    run_start = 1'b1;
    rk_ready  = 1'b1;
    step();
    run_start = 1'b0;
    for (int n = 0; n < 15; n++) begin
      k = dir ? 14 - n : n;
      check_bit($sformatf("run%0d_valid_%0d", dir, n), rk_valid, 1'b1);
      check($sformatf("run%0d_idx_%0d", dir, n), KW'(rk_idx), KW'(k));
      check($sformatf("run%0d_key_%0d", dir, n), rk_out, rk_tab[k]);
      check_bit($sformatf("run%0d_last_%0d", dir, n), rk_last, n == 14);
      check_bit($sformatf("run%0d_done_early_%0d", dir, n), run_done, 1'b0);
      step();
    end
    check_bit($sformatf("run%0d_done", dir), run_done, 1'b1);
    check_bit($sformatf("run%0d_valid_after", dir), rk_valid, 1'b0);
    step();
    check_bit($sformatf("run%0d_done_pulse", dir), run_done, 1'b0);
    check_bit($sformatf("run%0d_keys_ready_after", dir), keys_ready, 1'b1);
    rk_ready = 1'b0;
  endtask

  initial begin
    int               xfers;
    bit               stalled;
    bit               done;
    logic [KW-1:0]    hold_out;
    logic [IDX_W-1:0] hold_idx;

    reset_n      = 1'b0;
    load_start   = 1'b0;
    short_key_hi = '0;
    skey_in      = '0;
    skey_valid   = 1'b0;
    skey_cnt     = '0;
    run_start    = 1'b0;
    run_dir      = 1'b0;
    rk_ready     = 1'b0;
    step();
    step();
    check_all_zero("reset");
    reset_n = 1'b1;
    step();

    // run_start with nothing loaded is ignored.
    run_start = 1'b1;
    step();
    run_start = 1'b0;
    check_bit("idle_run_ignored", rk_valid, 1'b0);

    do_load();
    full_run(1'b0);
    full_run(1'b1);

    // Backpressure with rk_ready pattern 1,0,0 repeating.
    run_dir   = 1'b0;
    run_start = 1'b1;
    step();
    run_start = 1'b0;
    xfers     = 0;
    stalled   = 1'b0;
    done      = 1'b0;
    hold_out  = '0;
    hold_idx  = '0;
    for (int c = 0; c < 100 && !done; c++) begin
      if (stalled) begin
        check($sformatf("stall_out_%0d", c), rk_out, hold_out);
        check($sformatf("stall_idx_%0d", c), KW'(rk_idx), KW'(hold_idx));
      end
      if (run_done) begin
        done = 1'b1;
      end else begin
        rk_ready = (c % 3 == 0);
        if (rk_valid && rk_ready) begin
          check($sformatf("bp_idx_%0d", xfers), KW'(rk_idx), KW'(xfers));
          check($sformatf("bp_key_%0d", xfers), rk_out, rk_tab[xfers % 15]);
          xfers++;
        end
        stalled  = rk_valid && !rk_ready;
        hold_out = rk_out;
        hold_idx = rk_idx;
        step();
      end
    end
    check("bp_transfers", KW'(xfers), KW'(15));
    check_bit("bp_run_done_seen", done, 1'b1);
    rk_ready = 1'b0;
    step();

    // Abort a forward run after 5 transfers with load_start (and a colliding run_start).
    run_dir   = 1'b0;
    run_start = 1'b1;
    rk_ready  = 1'b1;
    step();
    run_start = 1'b0;
    for (int n = 0; n < 5; n++) step();
    check("abort_idx_before", KW'(rk_idx), KW'(5));
    load_start   = 1'b1;
    short_key_hi = rk_tab[0];
    run_start    = 1'b1;
    step();
    load_start = 1'b0;
    run_start  = 1'b0;
    check_bit("abort_rk_valid", rk_valid, 1'b0);
    check_bit("abort_run_done", run_done, 1'b0);
    check_bit("abort_keys_ready", keys_ready, 1'b0);
    check_bit("abort_busy", busy, 1'b1);
    run_start = 1'b1;
    step();
    run_start = 1'b0;
    check_bit("load_run_ignored", rk_valid, 1'b0);
    step();
    check_bit("load_run_ignored2", rk_valid, 1'b0);
    check_bit("abort_no_done", run_done, 1'b0);
    rk_ready = 1'b0;
    stream_keys();
    full_run(1'b0);

    // Asynchronous reset mid-load, checked before the next clock edge.
    load_start   = 1'b1;
    short_key_hi = rk_tab[0];
    step();
    load_start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      skey_valid = 1'b1; skey_cnt = IDX_W'(i); skey_in = rk_tab[i];
      step();
    end
    skey_valid = 1'b0;
    check_bit("preasync_busy", busy, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async");
    #1;
    reset_n = 1'b1;
    step();
    run_start = 1'b1;
    step();
    run_start = 1'b0;
    check_bit("postreset_run_ignored", rk_valid, 1'b0);
    check_bit("postreset_keys_ready", keys_ready, 1'b0);
    check_bit("postreset_busy", busy, 1'b0);
    do_load();
    full_run(1'b1);

`ifdef AES_RKS_PARITY_EN
    dut.slot_mem[3][5] = ~dut.slot_mem[3][5];
    run_dir   = 1'b0;
    run_start = 1'b1;
    rk_ready  = 1'b1;
    step();
    run_start = 1'b0;
    check_bit("par_clean_idx0", parity_err, 1'b0);
    for (int n = 1; n <= 3; n++) step();
    check("par_idx", KW'(rk_idx), KW'(3));
    check_bit("par_err_idx3", parity_err, 1'b1);
    for (int n = 4; n <= 15; n++) step();
    check_bit("par_run_done", run_done, 1'b1);
    check_bit("par_err_sticky", parity_err, 1'b1);
    rk_ready = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes256_round_key_store.md
Name: aes256_round_key_store

Overview:
- Downstream neighbour of the AES-256 key expander.
- Captures round key 0 from the raw 256-bit key when a load starts, then captures round keys 1..14 as the expander streams them, tagged by its round counter.
- Once all 15 keys are held, serves them one per handshake to the round datapath.
- Serving order is forward (0..14, encrypt) or reverse (14..0, decrypt).

Parameters:
- KW, 128, round-key width in bits.
- NUM_KEYS, 15, number of round-key slots (AES-256: Nr+1). Only 15 is supported.
- IDX_W, 4, width of slot index and expander counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle pulse; begins a new key load. Same cycle the expander's start is pulsed.
- short_key_hi  in  KW  short_key[255:128]; captured as slot 0 on load_start.
- skey_in  in  KW  expander subkey output.
- skey_valid  in  1  expander valid_skey.
- skey_cnt  in  IDX_W  expander round counter; equals the slot index of skey_in.
- keys_ready  out  1  all 15 slots loaded.
- run_start  in  1  one-cycle pulse; begins serving keys.
- run_dir  in  1  0 = forward, 1 = reverse; sampled with run_start.
- rk_out  out  KW  round key being offered.
- rk_idx  out  IDX_W  slot index of rk_out.
- rk_valid  out  1  rk_out valid.
- rk_ready  in  1  consumer accepts; a transfer occurs when rk_valid && rk_ready.
- rk_last  out  1  rk_out is the final key of the run (14 forward, 0 reverse).
- run_done  out  1  one-cycle pulse after the last transfer.
- busy  out  1  state is LOAD or RUN.

Behaviour:
- Reset (reset_n low, any time, immediate):
  - State goes to IDLE; slot_valid[14:0] is cleared.
  - All outputs go to 0: rk_out = 0, rk_idx = 0, rk_valid = 0, rk_last = 0, keys_ready = 0, run_done = 0, busy = 0.
  - Key storage contents are don't-care.
- States: IDLE, LOAD, READY, RUN.
- load_start, from any state, has highest priority:
  - slot0 <= short_key_hi; slot_valid <= 15'b1; keys_ready <= 0; rk_valid <= 0; state <= LOAD.
  - A run in progress is aborted with no run_done.
- LOAD:
  - On skey_valid with 1 <= skey_cnt <= 14: slot[skey_cnt] <= skey_in and its valid bit is set.
  - skey_cnt of 0 or 15 is ignored.
  - Rewriting a valid slot overwrites it silently.
  - When slot_valid becomes all ones: state <= READY and keys_ready = 1 from the following cycle.
- skey_valid outside LOAD (including the load_start cycle itself) is ignored.
- READY:
  - run_start loads the pointer: 0 if run_dir = 0, 14 if run_dir = 1.
  - State goes to RUN; rk_valid = 1 the next cycle with rk_out = slot[pointer].
  - Latency: run_start to first rk_valid is 1 cycle.
- run_start in IDLE, LOAD or RUN is ignored.
- RUN:
  - rk_out, rk_idx and rk_last are registered and held stable while rk_valid && !rk_ready.
  - On a transfer of a non-last key: pointer advances by +1 (forward) or -1 (reverse) and the new key is presented the next cycle, with no bubble.
  - On a transfer of the last key: rk_valid <= 0, run_done = 1 for one cycle, state <= READY.
  - With rk_ready held high, 15 keys go out on 15 consecutive cycles.
- keys_ready stays 1 through READY and RUN; keys are reusable for any number of runs until the next load_start or reset.
- Simultaneous load_start and run_start: load wins and run_start is dropped.

Optional Feature:
- Macro: AES_RKS_PARITY_EN.
- When defined:
  - Each slot stores 16 extra bits: even parity per byte, computed on write.
  - On every rk_out load, parity is rechecked.
  - Output parity_err (1 bit) is registered and aligned with rk_valid; it is sticky until load_start or reset.
  - A parity error does not stall the handshake.
- When undefined: no parity storage, no parity_err port.

Test Plan:
- Key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 plus expander model, then forward run with rk_ready = 1:
  - Required: keys_ready rises after slot 14 is written.
  - Then 15 consecutive transfers: idx 0 = 603deb1015ca71be2b73aef0857d7781, idx 1 = 1f352c073b6108d72d9810a30914dff4, idx 2 = 9ba354118e6925afa51a8b5f2067fcde, idx 14 = fe4890d1e6188d0b046df344706c631e.
  - rk_last only on idx 14; run_done pulses the next cycle.
- Reverse run with run_dir = 1 -> first rk_idx = 14 with fe4890d1e6188d0b046df344706c631e, last rk_idx = 0, rk_last on idx 0.
- rk_ready toggled 1,0,0,1,... -> rk_out and rk_idx unchanged during the 0 cycles; no key skipped or duplicated; exactly 15 transfers.
- load_start during RUN after 5 transfers -> rk_valid = 0 next cycle, no run_done, keys_ready = 0, busy = 1. A run_start issued before the reload completes is ignored.
- Reset pulsed asynchronously mid-LOAD -> all outputs 0 immediately. A following run_start is ignored until a full reload completes.
- With AES_RKS_PARITY_EN, force-flip one stored bit of slot 3 -> parity_err = 1 with idx 3, and it stays 1 through run_done.
